// File: rtl/latch_write_arbiter.sv
// Two-requester round-robin arbiter driving a shared bank of edge-triggered latches.
// The winner's address/data are captured at grant; one trigger pulse per write, then a guard gap.
module latch_write_arbiter #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int AW    = 2,
  parameter int PULSE = 2,
  parameter int GAP   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_data,
  output logic          a_ack,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic [W-1:0]  b_data,
  output logic          b_ack,
  output logic [N-1:0]  trig,
  output logic [W-1:0]  d,
  output logic          err,
  output logic          busy
);

  // state  | meaning
  // IDLE   | sample requests, arbitrate, capture winner's addr/data
  // SETUP  | data settles on d, all triggers low (1 cycle)
  // STROBE | trig[sel] high for PULSE cycles
  // HOLD   | triggers low, d held for GAP cycles; ack/err in first cycle
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0]  PULSE_TC = 4'(PULSE - 1);
  localparam logic [3:0]  GAP_TC   = 4'(GAP - 1);
  localparam logic [AW:0] N_LIM    = (AW + 1)'(N);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] sel;
  logic          win_b;
  logic          last_b;
  logic          grant;
  logic          grant_b;
  logic          first_hold;
  logic          oob;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant     = 1'b1;
          // on a tie, the side that did not win last time takes it
          grant_b   = b_req && (!a_req || !last_b);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = PULSE_TC;
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = GAP_TC;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      sel    <= '0;
      d      <= '0;
      win_b  <= 1'b0;
      last_b <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        sel    <= grant_b ? b_addr : a_addr;
        d      <= grant_b ? b_data : a_data;
        win_b  <= grant_b;
        last_b <= grant_b;
      end
    end
  end

  assign first_hold = (state == HOLD) && (cnt == GAP_TC);
  assign oob        = {1'b0, sel} >= N_LIM;
  assign a_ack      = first_hold && !win_b;
  assign b_ack      = first_hold && win_b;
  assign err        = first_hold && oob;
  assign busy       = (state != IDLE);

  // an out-of-range sel matches no index, so trig stays zero
  always_comb begin
    trig = '0;
    if (state == STROBE) begin
      for (int i = 0; i < N; i++) begin
        if (sel == AW'(i)) trig[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed vector table, hand sequences for multi-cycle
// corners, then constrained-random traffic against a transaction-timing reference model.
module tb_latch_write_arbiter;
  localparam int W = 8, N = 3, AW = 2, P = 2, G = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_data = '0, b_data = '0;
  logic          a_ack, b_ack, err, busy;
  logic [N-1:0]  trig;
  logic [W-1:0]  d;

  int checks = 0;
  int errors = 0;

  latch_write_arbiter #(.W(W), .N(N), .AW(AW), .PULSE(P), .GAP(G)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .trig(trig), .d(d), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r, ar;
    logic [AW-1:0] aa;
    logic [W-1:0]  ad;
    logic          br;
    logic [AW-1:0] ba;
    logic [W-1:0]  bd;
    logic [N-1:0]  et;
    logic [W-1:0]  ed;
    logic          eaa, eba, ee, ebz;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic r, logic ar, logic [AW-1:0] aa, logic [W-1:0] ad,
                              logic br, logic [AW-1:0] ba, logic [W-1:0] bd,
                              logic [N-1:0] et, logic [W-1:0] ed,
                              logic eaa, logic eba, logic ee, logic ebz);
    vec_t v;
    v.r = r; v.ar = ar; v.aa = aa; v.ad = ad; v.br = br; v.ba = ba; v.bd = bd;
    v.et = et; v.ed = ed; v.eaa = eaa; v.eba = eba; v.ee = ee; v.ebz = ebz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] et, input logic [W-1:0] ed,
                            input logic eaa, input logic eba, input logic ee, input logic ebz);
    chk({tag, ".trig"},  32'(trig),  32'(et));
    chk({tag, ".d"},     32'(d),     32'(ed));
    chk({tag, ".a_ack"}, 32'(a_ack), 32'(eaa));
    chk({tag, ".b_ack"}, 32'(b_ack), 32'(eba));
    chk({tag, ".err"},   32'(err),   32'(ee));
    chk({tag, ".busy"},  32'(busy),  32'(ebz));
    chk({tag, ".ack_excl"}, 32'(a_ack && b_ack), 32'(0));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: timing derived purely from the grant edge k
  // (k+1 setup, k+2..k+1+P trigger, k+2+P ack, idle again at k+2+P+G).
  int            m_cyc = 0, m_g = 0;
  bit            m_active = 1'b0, m_win_b = 1'b0, m_last_b = 1'b1;
  logic [AW-1:0] m_sel = '0;
  logic [W-1:0]  m_d = '0;

  task automatic model_edge();
    bit prev_idle, wb;
    m_cyc++;
    if (rst) begin
      m_active = 1'b0; m_d = '0; m_sel = '0; m_last_b = 1'b1;
    end else begin
      prev_idle = !m_active || ((m_cyc - 1 - m_g) >= 2 + P + G);
      if (prev_idle && (a_req || b_req)) begin
        wb       = (a_req && b_req) ? !m_last_b : b_req;
        m_g      = m_cyc - 1;
        m_active = 1'b1;
        m_win_b  = wb;
        m_last_b = wb;
        m_sel    = wb ? b_addr : a_addr;
        m_d      = wb ? b_data : a_data;
      end
    end
  endtask

  task automatic model_check();
    int off;
    logic [N-1:0] et;
    logic ack, oob;
    off = m_cyc - m_g;
    oob = int'(m_sel) >= N;
    et  = '0;
    if (m_active && off >= 2 && off <= 1 + P && !oob) et = N'(1) << m_sel;
    ack = m_active && (off == 2 + P);
    check_outs("rnd", et, m_d, ack && !m_win_b, ack && m_win_b, ack && oob,
               m_active && (off <= 1 + P + G));
  endtask

  initial begin
    string     seq;
    int        low_run, acks_seen;
    bit        seen_pulse, got;
    int        trig_seen;

    vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 3'b000, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2, 8'h5A, 0, 0, 8'h00, 3'b000, 8'h5A, 0, 0, 0, 1);
    vecs[2]  = mk(0, 1, 2, 8'h5A, 0, 0, 8'h00, 3'b100, 8'h5A, 0, 0, 0, 1);
    vecs[3]  = mk(0, 1, 2, 8'h5A, 0, 0, 8'h00, 3'b100, 8'h5A, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 2, 8'h5A, 0, 0, 8'h00, 3'b000, 8'h5A, 1, 0, 0, 1);
    vecs[5]  = mk(0, 0, 2, 8'h5A, 0, 0, 8'h00, 3'b000, 8'h5A, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 3'b000, 8'h00, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 8'h11, 1, 1, 8'h22, 3'b000, 8'h11, 0, 0, 0, 1);
    vecs[8]  = mk(0, 1, 0, 8'h11, 1, 1, 8'h22, 3'b001, 8'h11, 0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 0, 8'h11, 1, 1, 8'h22, 3'b001, 8'h11, 0, 0, 0, 1);
    vecs[10] = mk(0, 1, 0, 8'h11, 1, 1, 8'h22, 3'b000, 8'h11, 1, 0, 0, 1);
    vecs[11] = mk(0, 0, 0, 8'h11, 1, 1, 8'h22, 3'b000, 8'h11, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 8'h11, 1, 1, 8'h22, 3'b000, 8'h22, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 8'h11, 1, 1, 8'h22, 3'b010, 8'h22, 0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 8'h11, 1, 1, 8'h22, 3'b010, 8'h22, 0, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 8'h11, 1, 1, 8'h22, 3'b000, 8'h22, 0, 1, 0, 1);
    vecs[16] = mk(0, 0, 0, 8'h11, 0, 1, 8'h22, 3'b000, 8'h22, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 8'h11, 1, 3, 8'h33, 3'b000, 8'h33, 0, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 8'h11, 1, 3, 8'h33, 3'b000, 8'h33, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 8'h11, 1, 3, 8'h33, 3'b000, 8'h33, 0, 0, 0, 1);
    vecs[20] = mk(0, 0, 0, 8'h11, 1, 3, 8'h33, 3'b000, 8'h33, 0, 1, 1, 1);
    vecs[21] = mk(0, 0, 0, 8'h11, 0, 3, 8'h33, 3'b000, 8'h33, 0, 0, 0, 0);

    // directed table
    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].r;
      a_req = vecs[i].ar; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_req = vecs[i].br; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      cyc();
      check_outs($sformatf("vec%0d", i), vecs[i].et, vecs[i].ed,
                 vecs[i].eaa, vecs[i].eba, vecs[i].ee, vecs[i].ebz);
    end

    // fairness with both requests held continuously
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; cyc();
    rst = 1'b0;
    a_req = 1'b1; a_addr = 0; a_data = 8'h11;
    b_req = 1'b1; b_addr = 1; b_data = 8'h22;
    seq = ""; low_run = 0; seen_pulse = 1'b0; acks_seen = 0;
    for (int c = 0; c < 40 && acks_seen < 5; c++) begin
      cyc();
      if (a_ack) begin seq = {seq, "A"}; acks_seen++; end
      if (b_ack) begin seq = {seq, "B"}; acks_seen++; end
      if (trig != '0) begin
        if (seen_pulse && low_run > 0) chk("fair.gap_ok", 32'(low_run >= G + 2), 32'(1));
        seen_pulse = 1'b1; low_run = 0;
      end else begin
        low_run++;
      end
    end
    checks++;
    if (seq != "ABABA") begin
      errors++;
      $display("FAIL fair.order got %s want ABABA", seq);
    end
    a_req = 1'b0; b_req = 1'b0; cyc(); cyc(); cyc();

    // reset during the second trigger-high cycle
    rst = 1'b1; cyc(); rst = 1'b0;
    a_req = 1'b1; a_addr = 1; a_data = 8'h77;
    cyc(); chk("rstmid.setup_d", 32'(d), 32'h77);
    cyc(); chk("rstmid.strobe1", 32'(trig), 32'(3'b010));
    cyc(); chk("rstmid.strobe2", 32'(trig), 32'(3'b010));
    rst = 1'b1;
    cyc(); check_outs("rstmid.abort", 3'b000, 8'h00, 0, 0, 0, 0);
    rst = 1'b0;
    b_req = 1'b1; b_addr = 2; b_data = 8'h44;
    cyc(); chk("rstmid.tie_d", 32'(d), 32'h77);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cyc();
      if (a_ack || b_ack) begin
        got = 1'b1;
        chk("rstmid.first_ack_a", 32'(a_ack), 32'(1));
      end
    end
    if (!got) begin checks++; errors++; $display("FAIL rstmid.ack_timeout got none want a_ack"); end
    a_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      cyc();
      if (b_ack) got = 1'b1;
    end
    chk("rstmid.b_served", 32'(got), 32'(1));
    b_req = 1'b0; cyc(); cyc();

    // input churn after the grant edge
    a_req = 1'b1; a_addr = 0; a_data = 8'hAA;
    cyc(); chk("churn.setup_d", 32'(d), 32'hAA);
    a_addr = 2; a_data = 8'h55;
    got = 1'b0; trig_seen = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      cyc();
      chk("churn.d", 32'(d), 32'hAA);
      if (trig == 3'b001) trig_seen++;
      if (a_ack) got = 1'b1;
    end
    chk("churn.trig_cycles", 32'(trig_seen), 32'(P));
    chk("churn.acked", 32'(got), 32'(1));
    a_req = 1'b0; cyc(); cyc();
    chk("churn.latched_d", 32'(d), 32'hAA);

    // randomized traffic vs reference model
    rst = 1'b1;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (c > 0) model_check();
      rst = (c < 1) || ($urandom_range(0, 59) == 0);
      if (a_req && a_ack) begin
        a_req = $urandom_range(0, 1);
        a_addr = AW'($urandom_range(0, 3)); a_data = W'($urandom);
      end else if (!a_req && $urandom_range(0, 9) < 3) begin
        a_req = 1'b1; a_addr = AW'($urandom_range(0, 3)); a_data = W'($urandom);
      end
      if (b_req && b_ack) begin
        b_req = $urandom_range(0, 1);
        b_addr = AW'($urandom_range(0, 3)); b_data = W'($urandom);
      end else if (!b_req && $urandom_range(0, 9) < 3) begin
        b_req = 1'b1; b_addr = AW'($urandom_range(0, 3)); b_data = W'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 SHALL have parameter W, default 8, data width of the shared latch bank.
REQ-002 SHALL have parameter N, default 4, number of edge-triggered latches in the bank.
REQ-003 SHALL have parameter AW, default 2, address width; N <= 2^AW.
REQ-004 SHALL have parameter PULSE, default 2, trigger high time in clk cycles, legal range 1..15.
REQ-005 SHALL have parameter GAP, default 1, minimum trigger low time after each strobe, legal range 1..15.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 a_req  input  1  requester A write request, level.
REQ-009 a_addr  input  AW  requester A target latch index.
REQ-010 a_data  input  W  requester A write data.
REQ-011 a_ack  output  1  requester A completion pulse.
REQ-012 b_req, b_addr, b_data, b_ack  same as A  requester B port.
REQ-013 trig  output  N  per-latch trigger, one-hot or zero.
REQ-014 d  output  W  shared latch data bus.
REQ-015 err  output  1  out-of-range address pulse.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD.
REQ-018 IDLE: requests are sampled only here; with no request pending, IDLE SHALL hold.
REQ-019 IDLE -> SETUP on any request; the winner's addr and data SHALL be registered into sel and d at that edge.
REQ-020 Arbitration SHALL be round-robin. A single requester wins outright. On simultaneous requests, the requester not granted last SHALL win.
REQ-021 last_grant SHALL update on every grant.
REQ-022 SETUP: trig SHALL be all zero and d stable; lasts exactly 1 cycle; then -> STROBE.
REQ-023 STROBE: trig[sel] = 1, all other bits 0, for exactly PULSE cycles; d SHALL stay stable; then -> HOLD.
REQ-024 If sel >= N, trig SHALL stay all zero throughout STROBE.
REQ-025 HOLD: trig SHALL be all zero and d SHALL remain unchanged for exactly GAP cycles; then -> IDLE.
REQ-026 In the first HOLD cycle, the winner's ack SHALL pulse high for exactly 1 cycle.
REQ-027 In the first HOLD cycle, err SHALL pulse for 1 cycle if sel >= N.
REQ-028 Latency: req seen in IDLE at edge k -> SETUP in cycle k+1 -> trig high cycles k+2..k+1+PULSE -> ack in cycle k+2+PULSE -> IDLE in cycle k+2+PULSE+GAP.
REQ-029 A requester SHALL hold req, addr and data stable until its ack.
REQ-030 The arbiter SHALL ignore requester input changes after the grant edge; the registered copy governs.
REQ-031 req still high in the IDLE cycle after HOLD SHALL be treated as a new request.
REQ-032 Two consecutive trig pulses on any bit SHALL be separated by at least GAP+2 low cycles (HOLD + IDLE + SETUP).
REQ-033 Only one of a_ack or b_ack SHALL be high in any cycle.
REQ-034 Counters SHALL be 4-bit and SHALL not wrap for legal PULSE/GAP values.
REQ-035 A losing request SHALL stay pending, with no timeout.
REQ-036 The losing request SHALL be granted at the next IDLE evaluation, because round-robin guarantees it.

Reset
REQ-037 While rst is high: state = IDLE, trig = 0, d = 0, sel = 0, a_ack = b_ack = err = busy = 0, counters = 0, last_grant = B (so A wins the first tie).
REQ-038 rst asserted mid-operation SHALL drop trig and abort the transaction with no ack.
REQ-039 The first post-reset grant SHALL be evaluated on the first edge after rst is low.

Verification
REQ-040 Single write: A writes addr 2, data 8'h5A, PULSE=2, GAP=1 -> d = 5A from cycle 1; trig = 4'b0100 in cycles 2-3; a_ack in cycle 4; busy low in cycle 5.
REQ-041 Tie after reset: A (addr 0, 8'h11) and B (addr 1, 8'h22) both request -> A served first, then B; trig 0001 then 0010; ack order a then b; no cycle with both acks high.
REQ-042 Fairness: A and B both request continuously, with req held after ack -> grants alternate B, A, B, A after the first A; trig low gap >= GAP+2 cycles each time.
REQ-043 Out of range: N=3, AW=2, B writes addr 3 -> trig stays 0; b_ack and err pulse together in the first HOLD cycle.
REQ-044 Reset mid-STROBE: rst during the second trig-high cycle -> next cycle trig = 0, d = 0, no ack; subsequent request handled normally, and A wins the tie.
REQ-045 Input churn: A changes a_data during STROBE -> d and the latched result equal the value registered at grant.
